// File: rtl/axis_route_ctrl.sv
// Per-region TDEST route registers, updated only between packets; stalls the target region while the route changes.
// Latency: idle region done 2+SETTLE_CYCLES cycles after accept; busy region waits for the tlast handshake.
// Backpressure: cfg_ready only in IDLE, done is a pulse. Optional drain timeout under ROUTE_CTRL_TIMEOUT_EN.
`ifndef N_REGIONS
`define N_REGIONS 4
`endif

module axis_route_ctrl #(
  parameter int         N_ID           = `N_REGIONS,
  parameter int         ID_BITS        = (N_ID > 1) ? $clog2(N_ID) : 1,
  parameter logic [7:0] RESET_ROUTE    = 8'h00,
  parameter int         SETTLE_CYCLES  = 2,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ID_BITS-1:0]  cfg_id,
  input  logic [7:0]          cfg_route,
  output logic                cfg_done_valid,
  output logic [ID_BITS-1:0]  cfg_done_id,
  output logic                cfg_done_err,
  input  logic [N_ID-1:0]     mon_tvalid,
  input  logic [N_ID-1:0]     mon_tready,
  input  logic [N_ID-1:0]     mon_tlast,
  output logic [N_ID-1:0]     stall,
  output logic [N_ID*8-1:0]   route
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_EOP, S_SETTLE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ID_BITS-1:0]      id_q, id_d;
  logic [7:0]              new_route_q, new_route_d;
  logic                    err_q, err_d;
  logic [3:0]              settle_cnt_q, settle_cnt_d;
  logic [N_ID-1:0]         in_pkt_q, in_pkt_d;
  logic [N_ID-1:0][7:0]    route_q, route_d;
  logic                    force_eop;
  logic                    bad_id;

  assign bad_id = ({1'b0, cfg_id} >= (ID_BITS+1)'(N_ID));

`ifdef ROUTE_CTRL_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d  = '0;
    force_eop = 1'b0;
    if (state_q == S_WAIT_EOP && in_pkt_q[id_q]) begin
      if (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1)) force_eop = 1'b1;
      else                                          to_cnt_d  = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign force_eop = 1'b0;
`endif

  // Packet tracking runs for every region regardless of FSM state.
  always_comb begin
    in_pkt_d = in_pkt_q;
    for (int i = 0; i < N_ID; i++) begin
      if (mon_tvalid[i] && mon_tready[i]) in_pkt_d[i] = ~mon_tlast[i];
    end
    if (force_eop) in_pkt_d[id_q] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    new_route_d  = new_route_q;
    err_d        = err_q;
    settle_cnt_d = '0;
    route_d      = route_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          id_d        = cfg_id;
          new_route_d = cfg_route;
          err_d       = bad_id;
          state_d     = bad_id ? S_DONE : S_WAIT_EOP;
        end
      end
      S_WAIT_EOP: begin
        if (!in_pkt_q[id_q] || force_eop) begin
          route_d[id_q] = new_route_q;
          err_d         = err_q | force_eop;
          state_d       = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = S_DONE;
        else                                       settle_cnt_d = settle_cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      new_route_q  <= '0;
      err_q        <= 1'b0;
      settle_cnt_q <= '0;
      in_pkt_q     <= '0;
      route_q      <= {N_ID{RESET_ROUTE}};
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      new_route_q  <= new_route_d;
      err_q        <= err_d;
      settle_cnt_q <= settle_cnt_d;
      in_pkt_q     <= in_pkt_d;
      route_q      <= route_d;
    end
  end

  // Stall is asserted only once the target region is between packets, so no beat is cut.
  always_comb begin
    stall = '0;
    if ((state_q == S_WAIT_EOP && !in_pkt_q[id_q]) || state_q == S_SETTLE) stall[id_q] = 1'b1;
  end

  assign cfg_ready      = (state_q == S_IDLE);
  assign cfg_done_valid = (state_q == S_DONE);
  assign cfg_done_id    = (state_q == S_DONE) ? id_q : '0;
  assign cfg_done_err   = (state_q == S_DONE) & err_q;
  assign route          = route_q;

endmodule
